// File: rtl/tia_pkg.sv
// Shared constants and phase encoding for the TIA horizontal timing slice.
package tia_pkg;

  localparam int unsigned HcountW          = 6;
  localparam int unsigned HcountMaxDef     = 56;
  localparam int unsigned HsyncStartDef    = 4;
  localparam int unsigned HsyncEndDef      = 8;
  localparam int unsigned HblankEndDef     = 17;
  localparam int unsigned HblankEndHmDef   = 19;

  // S1 and S2 are the latch strobe phases; H1/H2 are the gaps between them.
  typedef enum logic [1:0] {
    PhS1 = 2'd0,
    PhH1 = 2'd1,
    PhS2 = 2'd2,
    PhH2 = 2'd3
  } phase_e;

endpackage

// File: rtl/tia_phase_gen.sv
// Four-phase colour-clock divider producing the non-overlapping phi1/phi2 strobes.
module tia_phase_gen
  import tia_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   sync_i,
  output phase_e ph_o,
  output logic   phi1_o,
  output logic   phi2_o,
  output logic   wrap_o
);

  phase_e ph_q, ph_d;

  always_comb begin
    ph_d = phase_e'(ph_q + 2'd1);
    if (sync_i) ph_d = PhS1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ph_q <= PhH2;
    else         ph_q <= ph_d;
  end

  assign ph_o   = ph_q;
  assign phi1_o = (ph_q == PhS1);
  assign phi2_o = (ph_q == PhS2);
  assign wrap_o = (ph_q == PhH2);

endmodule

// File: rtl/tia_hsync_sched.sv
// Horizontal line scheduler: hcount, sync/blank windows, WSYNC stall, RSYNC and HMOVE blank.
module tia_hsync_sched
  import tia_pkg::*;
#(
  parameter int unsigned HCOUNT_MAX       = HcountMaxDef,
  parameter int unsigned HSYNC_START      = HsyncStartDef,
  parameter int unsigned HSYNC_END        = HsyncEndDef,
  parameter int unsigned HBLANK_END       = HblankEndDef,
  parameter int unsigned HBLANK_END_HMOVE = HblankEndHmDef
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wsync_strobe,
  input  logic               rsync_strobe,
  input  logic               hmove_strobe,
  output logic               phi1,
  output logic               phi2,
  output logic [HcountW-1:0] hcount,
  output logic               line_start,
  output logic               hblank,
  output logic               hsync,
  output logic               rdy,
  output logic               hmove_active
);

  localparam logic [HcountW-1:0] HcMax   = HcountW'(HCOUNT_MAX);
  localparam logic [HcountW-1:0] HsStart = HcountW'(HSYNC_START);
  localparam logic [HcountW-1:0] HsEnd   = HcountW'(HSYNC_END);
  localparam logic [HcountW-1:0] HbEnd   = HcountW'(HBLANK_END);
  localparam logic [HcountW-1:0] HbEndHm = HcountW'(HBLANK_END_HMOVE);

  phase_e ph;
  logic   ph_wrap;

  tia_phase_gen u_phase_gen (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sync_i (rsync_strobe),
    .ph_o   (ph),
    .phi1_o (phi1),
    .phi2_o (phi2),
    .wrap_o (ph_wrap)
  );

  logic [HcountW-1:0] hcount_q, hcount_d, hc_next, blank_end;
  logic               hblank_q, hblank_d;
  logic               wsync_pending_q, wsync_pending_d;
  logic               hmove_pending_q, hmove_pending_d;
  logic               hmove_active_q, hmove_active_d;
  logic               at_max, ls_edge, count_edge;

  always_comb begin
    hc_next    = hcount_q + 6'd1;
    at_max     = (hcount_q == HcMax);
    // RSYNC and a natural wrap both land on hcount 0 / phase 0, so one line_start results.
    ls_edge    = rsync_strobe | (ph_wrap & at_max);
    count_edge = ph_wrap & ~rsync_strobe;
    blank_end  = hmove_active_q ? HbEndHm : HbEnd;

    hcount_d = hcount_q;
    if (ls_edge)         hcount_d = '0;
    else if (count_edge) hcount_d = hc_next;

    hblank_d = hblank_q;
    if (ls_edge)                                 hblank_d = 1'b1;
    else if (count_edge && hc_next == blank_end) hblank_d = 1'b0;

    // A strobe on the line_start edge wins, so the stall spans the whole next line.
    wsync_pending_d = wsync_pending_q;
    if (wsync_strobe) wsync_pending_d = 1'b1;
    else if (ls_edge) wsync_pending_d = 1'b0;

    hmove_pending_d = hmove_pending_q;
    if (hmove_strobe) hmove_pending_d = 1'b1;
    else if (ls_edge) hmove_pending_d = 1'b0;

    hmove_active_d = hmove_active_q;
    if (ls_edge)                               hmove_active_d = hmove_pending_q;
    else if (count_edge && hc_next == HbEndHm) hmove_active_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q        <= HcMax;
      hblank_q        <= 1'b1;
      wsync_pending_q <= 1'b0;
      hmove_pending_q <= 1'b0;
      hmove_active_q  <= 1'b0;
    end else begin
      hcount_q        <= hcount_d;
      hblank_q        <= hblank_d;
      wsync_pending_q <= wsync_pending_d;
      hmove_pending_q <= hmove_pending_d;
      hmove_active_q  <= hmove_active_d;
    end
  end

  assign hcount       = hcount_q;
  assign line_start   = (ph == PhS1) && (hcount_q == '0);
  assign hsync        = (hcount_q >= HsStart) && (hcount_q < HsEnd);
  assign hblank       = hblank_q;
  assign rdy          = ~wsync_pending_q;
  assign hmove_active = hmove_active_q;

endmodule

// File: tb/tb_tia_hsync_sched.sv
// Bench for tia_hsync_sched: directed vector table, random strobes vs a line-position model.
module tb_tia_hsync_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wsync_strobe, rsync_strobe, hmove_strobe;
  logic       phi1, phi2, line_start, hblank, hsync, rdy, hmove_active;
  logic [5:0] hcount;

  int checks = 0;
  int errors = 0;

  tia_hsync_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wsync_strobe (wsync_strobe),
    .rsync_strobe (rsync_strobe),
    .hmove_strobe (hmove_strobe),
    .phi1         (phi1),
    .phi2         (phi2),
    .hcount       (hcount),
    .line_start   (line_start),
    .hblank       (hblank),
    .hsync        (hsync),
    .rdy          (rdy),
    .hmove_active (hmove_active)
  );

  always #5 clk = ~clk;

  // Model: position within the 228-clk line; blank length fixed at the line start.
  int m_pos;
  bit m_started, m_wpend, m_hpend, m_line_ext;

  task automatic model_reset();
    m_pos = 227; m_started = 0; m_wpend = 0; m_hpend = 0; m_line_ext = 0;
  endtask

  task automatic model_edge(input bit w, input bit r, input bit h);
    bit ls;
    ls = r || (m_pos == 227);
    if (ls) begin
      m_line_ext = m_hpend;
      m_started  = 1;
    end
    m_wpend = w ? 1'b1 : (ls ? 1'b0 : m_wpend);
    m_hpend = h ? 1'b1 : (ls ? 1'b0 : m_hpend);
    m_pos   = ls ? 0 : m_pos + 1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d (pos %0d)", name, $time, act, exp, m_pos);
    end
  endtask

  task automatic check_model();
    int blank_len;
    blank_len = m_line_ext ? 76 : 68;
    chk("hcount", int'(hcount), m_pos / 4);
    chk("phi1", int'(phi1), int'(m_pos % 4 == 0));
    chk("phi2", int'(phi2), int'(m_pos % 4 == 2));
    chk("phi_overlap", int'(phi1 & phi2), 0);
    chk("line_start", int'(line_start), int'(m_pos == 0));
    chk("hsync", int'(hsync), int'(m_pos >= 16 && m_pos < 32));
    chk("hblank", int'(hblank), int'(!m_started || m_pos < blank_len));
    chk("hmove_active", int'(hmove_active), int'(m_started && m_line_ext && m_pos < 76));
    chk("rdy", int'(rdy), int'(!m_wpend));
  endtask

  // One clock: inputs held across the posedge, outputs sampled on the following negedge.
  task automatic cycle(input bit w, input bit r, input bit h);
    wsync_strobe = w; rsync_strobe = r; hmove_strobe = h;
    @(posedge clk);
    model_edge(w, r, h);
    @(negedge clk);
    wsync_strobe = 0; rsync_strobe = 0; hmove_strobe = 0;
    check_model();
  endtask

  typedef struct {
    int idle;
    bit w, r, h;
    int hc;
    bit ls, rdy, hb, hma;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 0; wsync_strobe = 0; rsync_strobe = 0; hmove_strobe = 0;
    model_reset();
    vecs = '{
      '{0,   0, 0, 0,  0, 1, 1, 1, 0},
      '{66,  0, 0, 0, 16, 0, 1, 1, 0},
      '{0,   0, 0, 0, 17, 0, 1, 0, 0},
      '{51,  1, 0, 0, 30, 0, 0, 0, 0},
      '{106, 0, 0, 0, 56, 0, 0, 0, 0},
      '{0,   0, 0, 0,  0, 1, 1, 1, 0},
      '{159, 0, 0, 1, 40, 0, 1, 0, 0},
      '{66,  0, 0, 0, 56, 0, 1, 0, 0},
      '{0,   0, 0, 0,  0, 1, 1, 1, 1},
      '{74,  0, 0, 0, 18, 0, 1, 1, 1},
      '{0,   0, 0, 0, 19, 0, 1, 0, 0},
      '{3,   1, 0, 0, 20, 0, 0, 0, 0},
      '{0,   0, 1, 0,  0, 1, 1, 1, 0},
      '{67,  0, 0, 0, 17, 0, 1, 0, 0},
      '{159, 1, 0, 0,  0, 1, 0, 1, 0},
      '{226, 0, 0, 0, 56, 0, 0, 0, 0},
      '{0,   0, 0, 0,  0, 1, 1, 1, 0},
      '{227, 0, 1, 0,  0, 1, 1, 1, 0},
      '{0,   0, 0, 0,  0, 0, 1, 1, 0}
    };

    repeat (2) @(negedge clk);
    check_model();
    chk("rst_hcount", int'(hcount), 56);
    chk("rst_rdy", int'(rdy), 1);
    rst_n = 1;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].idle; k++) cycle(0, 0, 0);
      cycle(vecs[i].w, vecs[i].r, vecs[i].h);
      chk($sformatf("vec%0d_hcount", i), int'(hcount), vecs[i].hc);
      chk($sformatf("vec%0d_line_start", i), int'(line_start), int'(vecs[i].ls));
      chk($sformatf("vec%0d_rdy", i), int'(rdy), int'(vecs[i].rdy));
      chk($sformatf("vec%0d_hblank", i), int'(hblank), int'(vecs[i].hb));
      chk($sformatf("vec%0d_hmove_active", i), int'(hmove_active), int'(vecs[i].hma));
    end

    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
            $urandom_range(0, 59) == 0);
    end

    // Mid-line asynchronous reset with WSYNC and HMOVE both pending.
    for (int k = 0; k < 30; k++) cycle(0, 0, 0);
    cycle(1, 0, 1);
    chk("pre_reset_rdy", int'(rdy), 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rdy", int'(rdy), 1);
    chk("async_hmove_active", int'(hmove_active), 0);
    chk("async_hblank", int'(hblank), 1);
    chk("async_hcount", int'(hcount), 56);
    chk("async_line_start", int'(line_start), 0);
    chk("async_phi1", int'(phi1), 0);
    @(negedge clk);
    rst_n = 1;
    cycle(0, 0, 0);
    chk("post_reset_line_start", int'(line_start), 1);
    for (int k = 0; k < 240; k++) cycle(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tia_hsync_sched.md
TIA_HSYNC_SCHED -- requirements
Module: tia_hsync_sched

Interface
REQ-001 Parameter HCOUNT_MAX, default 56: last horizontal count; the line is 57 counts of 4 clk (228 clk).
REQ-002 Parameter HSYNC_START, default 4: first count with hsync high.
REQ-003 Parameter HSYNC_END, default 8: first count with hsync low again.
REQ-004 Parameter HBLANK_END, default 17: count at which normal hblank clears (68 clk blank).
REQ-005 Parameter HBLANK_END_HMOVE, default 19: count at which extended hblank clears (76 clk blank).
REQ-006 clk  in  1  colour clock; the only clock.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 wsync_strobe  in  1  one-clk pulse on a CPU write to WSYNC.
REQ-009 rsync_strobe  in  1  one-clk pulse on a CPU write to RSYNC.
REQ-010 hmove_strobe  in  1  one-clk pulse on a CPU write to HMOVE.
REQ-011 phi1  out  1  first non-overlapping phase strobe for DL latches (s1).
REQ-012 phi2  out  1  second non-overlapping phase strobe for DL latches (s2).
REQ-013 hcount  out  6  horizontal count, 0..HCOUNT_MAX.
REQ-014 line_start  out  1  high for the single clk at hcount==0, phase 0.
REQ-015 hblank  out  1  horizontal blank.
REQ-016 hsync  out  1  horizontal sync.
REQ-017 rdy  out  1  CPU ready; low while a WSYNC is pending.
REQ-018 hmove_active  out  1  high while extended HMOVE blank is in force.

Function
REQ-019 Hold a 2-bit phase counter ph incrementing every clk, wrapping 3->0.
REQ-020 Decode phi1 = (ph==0) and phi2 = (ph==2); never both high; each 1 clk wide, period 4 clk.
REQ-021 Advance hcount on the edge where ph wraps 3->0; wrap HCOUNT_MAX->0 on that edge.
REQ-022 Decode hsync = (HSYNC_START <= hcount < HSYNC_END).
REQ-023 Set the hblank register on the line_start edge; clear it on the edge where hcount becomes HBLANK_END, or HBLANK_END_HMOVE when hmove_active.
REQ-024 Set wsync_pending on the edge after wsync_strobe; rdy = ~wsync_pending.
REQ-025 Clear wsync_pending on the edge entering line_start; if wsync_strobe coincides with that edge, set dominates and rdy stays low for the whole next line.
REQ-026 Set hmove_pending on the edge after hmove_strobe; move it to hmove_active on the next line_start edge, clearing hmove_pending unless a new hmove_strobe coincides.
REQ-027 Clear hmove_active on the edge where hcount becomes HBLANK_END_HMOVE.
REQ-028 Force ph=0 and hcount=0 on the edge after rsync_strobe; treat that edge as a line_start edge for REQ-023, REQ-025 and REQ-026.
REQ-029 On simultaneous rsync_strobe and natural wrap, produce exactly one line_start.

Reset
REQ-030 While rst_n low: ph=3, hcount=HCOUNT_MAX, wsync_pending=0, hmove_pending=0, hmove_active=0, hblank=1.
REQ-031 Outputs during reset: phi1=0, phi2=0, line_start=0, hsync=0, rdy=1, hblank=1, hmove_active=0, hcount=56.
REQ-032 First clk edge after rst_n rises: ph=0, hcount=0, line_start=1, phi1=1.
REQ-033 Asserting rst_n mid-line aborts any pending WSYNC/HMOVE immediately (rdy=1 asynchronously).

Structure
REQ-034 Put default count constants and the phase encoding in shared package tia_pkg.
REQ-035 Split the phase counter and phi1/phi2 decode into sub-module tia_phase_gen; keep all other state in tia_hsync_sched.

Verification
REQ-036 Release reset, run 456 clk -> line_start at clk 1 and 229; phi1 period 4; phi1 & phi2 never both high.
REQ-037 Free run -> hsync high 16 clk (hcount 4..7); hblank high 68 clk from line_start.
REQ-038 wsync_strobe at hcount 30 -> rdy low from next edge until line_start edge, then high.
REQ-039 hmove_strobe at hcount 40 -> next line hmove_active high and hblank high 76 clk; following line hblank 68 clk.
REQ-040 rsync_strobe at hcount 20 with wsync pending -> next edge hcount=0, line_start=1, rdy=1.
REQ-041 wsync_strobe coincident with line_start edge -> rdy low for the next 228 clk.
